// File: rtl/sm4_block_seq_if.sv
// Request/response bundle between a host and the SM4 block sequencer.
// Latency: none; plain wires with no storage.
// Backpressure: none; the host must hold off start_i while busy_o is high.
interface sm4_block_seq_if;
    logic         start_i;
    logic         decrypt_i;
    logic         keep_key_i;
    logic [127:0] key_i;
    logic [127:0] din_i;
    logic         busy_o;
    logic         done_o;
    logic [127:0] dout_o;
    logic         key_vld_o;

    modport master (
        output start_i, decrypt_i, keep_key_i, key_i, din_i,
        input  busy_o, done_o, dout_o, key_vld_o
    );

    modport slave (
        input  start_i, decrypt_i, keep_key_i, key_i, din_i,
        output busy_o, done_o, dout_o, key_vld_o
    );
endinterface

// File: rtl/sm4_block_seq.sv
// SM4 block sequencer: expands the key (optional) then runs 32 cipher rounds, one S-box byte per cycle.
// Latency: done 257 cycles after start with expansion, 129 cycles when stored round keys are reused.
// Backpressure: none; start_i is only sampled in IDLE and is dropped otherwise, never queued.
module sm4_block_seq (
    input  logic               clk_i,
    input  logic               rst_i,
    sm4_block_seq_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_KEXP, S_CRYPT, S_DONE} state_t;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    state_t      r_state, w_next;
    logic [4:0]  r_rnd;
    logic [1:0]  r_byte;
    logic [31:0] r_acc;
    logic [31:0] r_k0, r_k1, r_k2, r_k3;
    logic [31:0] r_x0, r_x1, r_x2, r_x3;
    logic [31:0] r_rk [32];
    logic        r_dec;
    logic        r_key_vld;
    logic [127:0] r_dout;

    logic        w_kexp, w_crypt, w_busy, w_last, w_start, w_to_kexp;
    logic [7:0]  w_ck_base;
    logic [31:0] w_ck, w_src, w_rs1, w_rs2, w_rd;
    logic [4:0]  w_rk_idx;

    assign w_kexp    = (r_state == S_KEXP);
    assign w_crypt   = (r_state == S_CRYPT);
    assign w_busy    = w_kexp | w_crypt;
    assign w_last    = (r_rnd == 5'd31) && (r_byte == 2'd3);
    assign w_start   = (r_state == S_IDLE) && bus.start_i;
    assign w_to_kexp = w_start && !(bus.keep_key_i && r_key_vld);

    // CK_r bytes are 28r, 28r+7, 28r+14, 28r+21 (mod 256), MSB first.
    assign w_ck_base = 8'({r_rnd, 4'b0000}) + 8'({r_rnd, 3'b000}) + 8'({r_rnd, 2'b00});
    assign w_ck      = {w_ck_base, w_ck_base + 8'd7, w_ck_base + 8'd14, w_ck_base + 8'd21};

    // Decryption walks the round keys backwards; 31-r is the bitwise inverse of r.
    assign w_rk_idx = r_dec ? ~r_rnd : r_rnd;
    assign w_src    = w_kexp ? r_k0 : r_x0;
    assign w_rs1    = (r_byte == 2'd0) ? w_src : r_acc;
    assign w_rs2    = w_kexp ? (r_k1 ^ r_k2 ^ r_k3 ^ w_ck)
                             : (r_x1 ^ r_x2 ^ r_x3 ^ r_rk[w_rk_idx]);

    riscv_crypto_fu_ssm4 u_ssm4 (
        .i_rs1         (w_rs1),
        .i_rs2         (w_rs2),
        .i_bs          (r_byte),
        .i_op_ssm4_ks  (w_kexp),
        .i_op_ssm4_ed  (w_crypt),
        .o_rd          (w_rd)
    );

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: expansion is skipped only when reuse is asked for and a key is held.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start) w_next = w_to_kexp ? S_KEXP : S_CRYPT;
            S_KEXP:  if (w_last)  w_next = S_CRYPT;
            S_CRYPT: if (w_last)  w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Round/byte counters advance while busy and restart at every state entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rnd  <= '0;
            r_byte <= '0;
        end else if (!w_busy || (w_next != r_state)) begin
            r_rnd  <= '0;
            r_byte <= '0;
        end else begin
            r_byte <= r_byte + 2'd1;
            if (r_byte == 2'd3) r_rnd <= r_rnd + 5'd1;
        end
    end

    // Request latch, key/data shift registers, accumulator and result capture.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_dec     <= 1'b0;
            r_acc     <= '0;
            r_k0      <= '0;
            r_k1      <= '0;
            r_k2      <= '0;
            r_k3      <= '0;
            r_x0      <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_x3      <= '0;
            r_key_vld <= 1'b0;
            r_dout    <= '0;
        end else begin
            if (w_start) begin
                r_dec <= bus.decrypt_i;
                r_x0  <= bus.din_i[127:96];
                r_x1  <= bus.din_i[95:64];
                r_x2  <= bus.din_i[63:32];
                r_x3  <= bus.din_i[31:0];
                if (w_to_kexp) begin
                    r_k0      <= bus.key_i[127:96] ^ FK0;
                    r_k1      <= bus.key_i[95:64]  ^ FK1;
                    r_k2      <= bus.key_i[63:32]  ^ FK2;
                    r_k3      <= bus.key_i[31:0]   ^ FK3;
                    r_key_vld <= 1'b0;
                end
            end
            if (w_busy) begin
                r_acc <= w_rd;
                if (r_byte == 2'd3) begin
                    if (w_kexp) begin
                        r_k0 <= r_k1;
                        r_k1 <= r_k2;
                        r_k2 <= r_k3;
                        r_k3 <= w_rd;
                    end else begin
                        r_x0 <= r_x1;
                        r_x1 <= r_x2;
                        r_x2 <= r_x3;
                        r_x3 <= w_rd;
                    end
                end
                if (w_last) begin
                    if (w_kexp) r_key_vld <= 1'b1;
                    else        r_dout    <= {w_rd, r_x3, r_x2, r_x1};
                end
            end
        end
    end

    // Round-key file: written once per expansion round, contents need no reset.
    always_ff @(posedge clk_i) begin
        if (w_kexp && (r_byte == 2'd3)) r_rk[r_rnd] <= w_rd;
    end

    assign bus.busy_o    = w_busy;
    assign bus.done_o    = (r_state == S_DONE);
    assign bus.dout_o    = r_dout;
    assign bus.key_vld_o = r_key_vld;
endmodule

// SM4 single-byte step: rd = rs1 ^ rol(L(sbox(rs2 byte bs)), 8*bs); purely combinational.
// Latency: zero cycles.
// Backpressure: none.
module riscv_crypto_fu_ssm4 (
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [1:0]  i_bs,
    input  logic        i_op_ssm4_ks,
    input  logic        i_op_ssm4_ed,
    output logic [31:0] o_rd
);
    localparam logic [0:255][7:0] SBOX = {
        8'hd6,8'h90,8'he9,8'hfe,8'hcc,8'he1,8'h3d,8'hb7,8'h16,8'hb6,8'h14,8'hc2,8'h28,8'hfb,8'h2c,8'h05,
        8'h2b,8'h67,8'h9a,8'h76,8'h2a,8'hbe,8'h04,8'hc3,8'haa,8'h44,8'h13,8'h26,8'h49,8'h86,8'h06,8'h99,
        8'h9c,8'h42,8'h50,8'hf4,8'h91,8'hef,8'h98,8'h7a,8'h33,8'h54,8'h0b,8'h43,8'hed,8'hcf,8'hac,8'h62,
        8'he4,8'hb3,8'h1c,8'ha9,8'hc9,8'h08,8'he8,8'h95,8'h80,8'hdf,8'h94,8'hfa,8'h75,8'h8f,8'h3f,8'ha6,
        8'h47,8'h07,8'ha7,8'hfc,8'hf3,8'h73,8'h17,8'hba,8'h83,8'h59,8'h3c,8'h19,8'he6,8'h85,8'h4f,8'ha8,
        8'h68,8'h6b,8'h81,8'hb2,8'h71,8'h64,8'hda,8'h8b,8'hf8,8'heb,8'h0f,8'h4b,8'h70,8'h56,8'h9d,8'h35,
        8'h1e,8'h24,8'h0e,8'h5e,8'h63,8'h58,8'hd1,8'ha2,8'h25,8'h22,8'h7c,8'h3b,8'h01,8'h21,8'h78,8'h87,
        8'hd4,8'h00,8'h46,8'h57,8'h9f,8'hd3,8'h27,8'h52,8'h4c,8'h36,8'h02,8'he7,8'ha0,8'hc4,8'hc8,8'h9e,
        8'hea,8'hbf,8'h8a,8'hd2,8'h40,8'hc7,8'h38,8'hb5,8'ha3,8'hf7,8'hf2,8'hce,8'hf9,8'h61,8'h15,8'ha1,
        8'he0,8'hae,8'h5d,8'ha4,8'h9b,8'h34,8'h1a,8'h55,8'had,8'h93,8'h32,8'h30,8'hf5,8'h8c,8'hb1,8'he3,
        8'h1d,8'hf6,8'he2,8'h2e,8'h82,8'h66,8'hca,8'h60,8'hc0,8'h29,8'h23,8'hab,8'h0d,8'h53,8'h4e,8'h6f,
        8'hd5,8'hdb,8'h37,8'h45,8'hde,8'hfd,8'h8e,8'h2f,8'h03,8'hff,8'h6a,8'h72,8'h6d,8'h6c,8'h5b,8'h51,
        8'h8d,8'h1b,8'haf,8'h92,8'hbb,8'hdd,8'hbc,8'h7f,8'h11,8'hd9,8'h5c,8'h41,8'h1f,8'h10,8'h5a,8'hd8,
        8'h0a,8'hc1,8'h31,8'h88,8'ha5,8'hcd,8'h7b,8'hbd,8'h2d,8'h74,8'hd0,8'h12,8'hb8,8'he5,8'hb4,8'hb0,
        8'h89,8'h69,8'h97,8'h4a,8'h0c,8'h96,8'h77,8'h7e,8'h65,8'hb9,8'hf1,8'h09,8'hc5,8'h6e,8'hc6,8'h84,
        8'h18,8'hf0,8'h7d,8'hec,8'h3a,8'hdc,8'h4d,8'h20,8'h79,8'hee,8'h5f,8'h3e,8'hd7,8'hcb,8'h39,8'h48
    };

    logic [7:0]  w_sb_in;
    logic [31:0] w_x, w_y, w_rot;

    // Byte pick, S-box, linear transform on the byte-0 position, then rotate into place.
    always_comb begin
        unique case (i_bs)
            2'd0:    w_sb_in = i_rs2[7:0];
            2'd1:    w_sb_in = i_rs2[15:8];
            2'd2:    w_sb_in = i_rs2[23:16];
            default: w_sb_in = i_rs2[31:24];
        endcase
        w_x = {24'b0, SBOX[w_sb_in]};
        // A byte at bits 7:0 never wraps under these shifts, so they equal the rotations of L / L'.
        if (i_op_ssm4_ks)      w_y = w_x ^ (w_x << 13) ^ (w_x << 23);
        else if (i_op_ssm4_ed) w_y = w_x ^ (w_x << 2) ^ (w_x << 10) ^ (w_x << 18) ^ (w_x << 24);
        else                   w_y = '0;
        unique case (i_bs)
            2'd0:    w_rot = w_y;
            2'd1:    w_rot = {w_y[23:0], w_y[31:24]};
            2'd2:    w_rot = {w_y[15:0], w_y[31:16]};
            default: w_rot = {w_y[7:0],  w_y[31:8]};
        endcase
        o_rd = w_rot ^ i_rs1;
    end
endmodule

// File: tb/tb_sm4_block_seq.sv
// Bench for sm4_block_seq: directed SM4 vectors, expected results queued at issue time.
// Latency: checks done_o lands exactly 257 / 129 cycles after the accepted start.
// Backpressure: exercises ignored starts while busy and a reset in the middle of expansion.
`timescale 1ns/1ps
module tb_sm4_block_seq;
    logic clk_i = 1'b0;
    logic rst_i;

    sm4_block_seq_if bus ();

    sm4_block_seq dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [127:0] KEY   = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] PT    = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT    = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [127:0] KEY_B = 128'hFFEEDDCCBBAA99887766554433221100;

    typedef struct {
        logic [127:0] dout;
        int           at;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   t0;

    always @(posedge clk_i) cyc++;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every done_o pops one queued expectation.
    always @(negedge clk_i) begin
        if (rst_i === 1'b0 && bus.done_o === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: done_o at cycle %0d, want none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_dout"}, bus.dout_o, mon_e.dout);
                check({mon_e.name, "_done_cycle"}, 128'(cyc), 128'(mon_e.at));
                check({mon_e.name, "_busy_in_done"}, 128'(bus.busy_o), 128'd0);
            end
        end
    end

    // Issue a start in one cycle; lat==0 means the job is expected to be killed.
    task automatic start_job(input logic [127:0] key, input logic [127:0] din, input logic dec,
                             input logic keep, input int lat, input logic [127:0] exp,
                             input string nm, output int t);
        exp_t e;
        @(posedge clk_i);
        #1;
        t = cyc;
        bus.key_i      = key;
        bus.din_i      = din;
        bus.decrypt_i  = dec;
        bus.keep_key_i = keep;
        bus.start_i    = 1'b1;
        if (lat != 0) begin
            e.dout = exp;
            e.at   = t + lat;
            e.name = nm;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
    endtask

    // Advance to #1 after the edge that starts cycle tgt.
    task automatic goto_cycle(input int tgt);
        do begin
            @(posedge clk_i);
            #1;
        end while (cyc < tgt);
    endtask

    // A stray start with another key while the job runs; must be dropped.
    task automatic stray_start(input int tgt, input string nm, input logic exp_kvld);
        goto_cycle(tgt);
        check({nm, "_busy"}, 128'(bus.busy_o), 128'd1);
        check({nm, "_key_vld"}, 128'(bus.key_vld_o), 128'(exp_kvld));
        bus.key_i      = KEY_B;
        bus.din_i      = KEY_B;
        bus.decrypt_i  = 1'b1;
        bus.keep_key_i = 1'b0;
        bus.start_i    = 1'b1;
        @(posedge clk_i);
        #1;
        bus.start_i = 1'b0;
    endtask

    // Return at the falling edge of the DONE cycle, or flag a timeout.
    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        while (bus.done_o !== 1'b1 && n < budget) begin
            @(negedge clk_i);
            n++;
        end
        if (bus.done_o !== 1'b1) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no done_o within %0d cycles, want done_o", nm, budget);
            sb.delete();
        end
    endtask

    initial begin
        rst_i          = 1'b1;
        bus.start_i    = 1'b0;
        bus.decrypt_i  = 1'b0;
        bus.keep_key_i = 1'b0;
        bus.key_i      = '0;
        bus.din_i      = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy",    128'(bus.busy_o),    128'd0);
        check("rst_done",    128'(bus.done_o),    128'd0);
        check("rst_dout",    bus.dout_o,          128'd0);
        check("rst_key_vld", 128'(bus.key_vld_o), 128'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Reuse asked for but nothing stored: must still expand.
        start_job(KEY, PT, 1'b0, 1'b1, 257, CT, "nokey_reuse", t0);
        wait_done(300, "nokey_reuse");
        check("nokey_key_vld", 128'(bus.key_vld_o), 128'd1);
        check("rk0",  128'(dut.r_rk[0]),  128'h F12186F9);
        check("rk31", 128'(dut.r_rk[31]), 128'h 9124A012);

        // Standard vector with fresh expansion and stray starts mid-job.
        start_job(KEY, PT, 1'b0, 1'b0, 257, CT, "std", t0);
        stray_start(t0 + 50,  "stray_kexp",  1'b0);
        stray_start(t0 + 200, "stray_crypt", 1'b1);
        wait_done(300, "std");

        // Back-to-back with stored keys, started the cycle after DONE.
        start_job(KEY, PT, 1'b0, 1'b1, 129, CT, "b2b_reuse", t0);
        wait_done(200, "b2b_reuse");
        check("rk0_after_stray",  128'(dut.r_rk[0]),  128'h F12186F9);
        check("rk31_after_stray", 128'(dut.r_rk[31]), 128'h 9124A012);

        // Decrypt with stored keys; the presented key must be ignored.
        start_job(KEY_B, CT, 1'b1, 1'b1, 129, PT, "dec_reuse", t0);
        wait_done(200, "dec_reuse");

        // Reset in the middle of expansion kills the job and the stored key.
        start_job(KEY, PT, 1'b0, 1'b0, 0, '0, "killed", t0);
        goto_cycle(t0 + 100);
        rst_i = 1'b1;
        #1;
        check("midrst_busy",    128'(bus.busy_o),    128'd0);
        check("midrst_done",    128'(bus.done_o),    128'd0);
        check("midrst_dout",    bus.dout_o,          128'd0);
        check("midrst_key_vld", 128'(bus.key_vld_o), 128'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        start_job(KEY, PT, 1'b0, 1'b1, 257, CT, "after_rst", t0);
        wait_done(300, "after_rst");

        repeat (300) @(posedge clk_i);
        #1;
        check("sb_drained", 128'(sb.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sm4_block_seq.md
# sm4_block_seq

Multi-cycle sequencer that drives one combinational `riscv_crypto_fu_ssm4` instance to perform full SM4 block encryption or decryption. Each instruction step processes one byte-select step per cycle: key expansion issues 128 `sm4ks` steps and the cipher issues 128 `sm4ed` steps. Expanded round keys are retained, so later blocks under the same key skip expansion. The block sits beside the execute-stage ALU as a standalone crypto accelerator, started by a single-cycle request.

## Interface
Parameters: none; all widths are fixed by SM4.

- `clk_i` input 1: clock.
- `rst_i` input 1: reset, asynchronous and active-high.
- `start_i` input 1: request pulse; sampled only in IDLE.
- `decrypt_i` input 1: 0 = encrypt, 1 = decrypt; latched at start.
- `keep_key_i` input 1: 1 = reuse the stored round keys if `key_vld_o` is set; latched at start.
- `key_i` input 128: master key MK, big-endian words MK0..MK3 = [127:96]..[31:0]; latched at start.
- `din_i` input 128: input block X0..X3, same word order; latched at start.
- `busy_o` output 1: high in KEXP or CRYPT.
- `done_o` output 1: single-cycle pulse; `dout_o` is valid from this cycle.
- `dout_o` output 128: result block; holds its value until the next `done_o`.
- `key_vld_o` output 1: round-key file holds a completed expansion.

## Operation
- **State machine: IDLE, KEXP, CRYPT, DONE.**
  - IDLE to KEXP on `start_i` when `keep_key_i`=0 or `key_vld_o`=0.
  - IDLE to CRYPT on `start_i` when `keep_key_i`=1 and `key_vld_o`=1.
  - KEXP to CRYPT after round 31, byte 3.
  - CRYPT to DONE after round 31, byte 3.
  - DONE to IDLE unconditionally.
- **Counters:** round counter r (5 bit) and byte counter b (2 bit). b increments every cycle in KEXP and CRYPT. r increments when b wraps from 3 to 0. Both clear on every state entry. The SM4 unit's `bs` is driven by b.
- **Accumulator:** 32-bit acc.
  - SM4 unit `rs1` = source word at b=0, otherwise acc.
  - Each cycle, acc is loaded with the unit result.
  - The unit result at b=3 is the round output.
- **KEXP** (`op_ssm4_ks`=1):
  - On start, K0..K3 are loaded with MK0^A3B1BAC6, MK1^56AA3350, MK2^677D9197, MK3^B27022DC.
  - Source word is K0. `rs2` = K1^K2^K3^CK_r.
  - CK_r byte j (j=0 is [31:24]) = (28r + 7j) mod 256, computed combinationally; no table.
  - At b=3: rk[r] is written with the result, then K shifts (K0←K1, K1←K2, K2←K3, K3←result).
  - On exit, `key_vld_o` is set.
- **CRYPT** (`op_ssm4_ed`=1):
  - X0..X3 are loaded from the latched `din_i`.
  - Source word is X0. `rs2` = X1^X2^X3^rk[k], where k = r for encrypt and k = 31−r for decrypt.
  - At b=3, X shifts the same way as K.
  - On exit, `dout_o` = {X3, X2, X1, X0}, i.e. the reversed transform.
- **Round-key file:** 32×32 flops, with no reset requirement on the contents.
- **Request handling:**
  - `start_i` outside IDLE is ignored, with no queueing.
  - `start_i` with `keep_key_i`=0 re-expands the key and overwrites rk and `key_vld_o`.
  - `key_vld_o` clears on KEXP entry and sets on KEXP exit. A reset during KEXP therefore leaves it 0.
- **Reset** (also mid-operation):
  - State returns to IDLE.
  - `busy_o`=0, `done_o`=0, `dout_o`=0, `key_vld_o`=0.
  - Counters, acc, K and X are cleared.

## Timing
- `start_i` is accepted at the clock edge ending cycle T.
- **With expansion:**
  - KEXP occupies cycles T+1..T+128.
  - CRYPT occupies cycles T+129..T+256.
  - `done_o`=1 in cycle T+257.
- **With key reuse:**
  - CRYPT occupies cycles T+1..T+128.
  - `done_o`=1 in cycle T+129.
- `busy_o`:
  - High exactly during the KEXP and CRYPT cycles.
  - Low in DONE and IDLE.
- **Back-to-back:** the earliest next start is sampled in the cycle after DONE.
- **Combinational path:** the SM4 unit path is one S-box plus the L rotation XOR per cycle. Nothing is registered inside the unit.

## Test plan
- **Standard vector:**
  - Stimulus: MK = din = 0123456789ABCDEFFEDCBA9876543210, encrypt, `keep_key_i`=0.
  - Response: `done_o` at T+257, `dout_o` = 681EDF34D206965E86B3E94F536E4246, rk[0] = F12186F9, rk[31] = 9124A012, `key_vld_o`=1.
- **Decrypt with key reuse:**
  - Stimulus: din = 681EDF34D206965E86B3E94F536E4246, `decrypt_i`=1, `keep_key_i`=1.
  - Response: `done_o` at T+129, `dout_o` = 0123456789ABCDEFFEDCBA9876543210.
- **Reuse requested with no valid key:**
  - Stimulus: after reset, start with `keep_key_i`=1.
  - Response: expansion still runs, `done_o` at T+257, and the result is correct.
- **Start while busy:**
  - Stimulus: pulse `start_i` with a different key at T+50 and T+200.
  - Response: both ignored; the first job's result and `done_o` timing are unchanged.
- **Mid-operation reset:**
  - Stimulus: assert `rst_i` at T+100 during KEXP.
  - Response: all outputs go to 0 immediately, including `key_vld_o`; no `done_o`. A new start after release yields the correct vector result.
- **Back-to-back reuse:**
  - Stimulus: start in the cycle after DONE, encrypt, `keep_key_i`=1, same plaintext.
  - Response: same ciphertext, with `done_o` 129 cycles later.
